// File: rtl/pipeline_hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } sb_entry_t;

    // x0 never forwards; the younger (EX) producer wins over MEM.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input sb_entry_t  ex,
        input sb_entry_t  mem
    );
        if (ex.regwrite && (ex.rd != 5'd0) && (rs == ex.rd)) begin
            return FWD_EXMEM;
        end
        if (mem.regwrite && (mem.rd != 5'd0) && (rs == mem.rd)) begin
            return FWD_MEMWB;
        end
        return FWD_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_controller_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Three-stage shift of in-flight destination register info.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import pipeline_hazard_controller_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  sb_entry_t id_entry,
    input  logic      idex_enable,
    input  logic      idex_clear,
    input  logic      exmem_enable,
    input  logic      exmem_clear,
    input  logic      memwb_enable,
    input  logic      memwb_clear,
    output sb_entry_t ex_entry,
    output sb_entry_t mem_entry,
    output sb_entry_t wb_entry
);

    sb_entry_t r_ex;
    sb_entry_t r_mem;
    sb_entry_t r_wb;

    // A clear inserts a bubble even when the stage enable is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            if (idex_clear) begin
                r_ex <= '0;
            end else if (idex_enable) begin
                r_ex <= id_entry;
            end

            if (exmem_clear) begin
                r_mem <= '0;
            end else if (exmem_enable) begin
                r_mem <= r_ex;
            end

            if (memwb_clear) begin
                r_wb <= '0;
            end else if (memwb_enable) begin
                r_wb <= r_mem;
            end
        end
    end

    assign ex_entry  = r_ex;
    assign mem_entry = r_mem;
    assign wb_entry  = r_wb;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Stall/flush/forward sequencer for the 5-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_enable,
    output logic             ifid_enable,
    output logic             idex_enable,
    output logic             exmem_enable,
    output logic             memwb_enable,
    output logic             ifid_clear,
    output logic             idex_clear,
    output logic             exmem_clear,
    output logic             memwb_clear,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t        r_state;
    hz_state_t        w_state_next;
    logic [TMR_W-1:0] r_timer;
    logic             r_mem_fault;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;

    sb_entry_t w_id_entry;
    sb_entry_t w_sb_ex;
    sb_entry_t w_sb_mem;
    sb_entry_t w_sb_wb;
    logic      w_load_use;
    logic      w_run_eval;
    logic      w_unused_wb;

    assign w_id_entry = '{rd: id_rd, regwrite: id_regwrite, memread: id_memread};

    hazard_scoreboard u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .id_entry     (w_id_entry),
        .idex_enable  (idex_enable),
        .idex_clear   (idex_clear),
        .exmem_enable (exmem_enable),
        .exmem_clear  (exmem_clear),
        .memwb_enable (memwb_enable),
        .memwb_clear  (memwb_clear),
        .ex_entry     (w_sb_ex),
        .mem_entry    (w_sb_mem),
        .wb_entry     (w_sb_wb)
    );

    // WB->ID hazards are resolved by the register file bypass.
    assign w_unused_wb = ^w_sb_wb;

    assign w_load_use = w_sb_ex.memread && w_sb_ex.regwrite && (w_sb_ex.rd != 5'd0) &&
                        ((id_uses_rs1 && (id_rs1 == w_sb_ex.rd)) ||
                         (id_uses_rs2 && (id_rs2 == w_sb_ex.rd)));

    always_comb begin
        w_state_next = r_state;
        w_run_eval   = 1'b0;
        pc_enable    = 1'b0;
        ifid_enable  = 1'b0;
        idex_enable  = 1'b0;
        exmem_enable = 1'b0;
        memwb_enable = 1'b0;
        ifid_clear   = 1'b0;
        idex_clear   = 1'b0;
        exmem_clear  = 1'b0;
        memwb_clear  = 1'b0;

        case (r_state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    w_state_next = MEM_WAIT;
                end else begin
                    w_run_eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    w_state_next = RUN;
                    w_run_eval   = 1'b1;
                end else if (r_timer == TMR_W'(MEM_TIMEOUT)) begin
                    w_state_next = FAULT;
                end
            end
            FAULT: begin
                w_state_next = FAULT;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase

        if (w_run_eval) begin
            pc_enable    = 1'b1;
            ifid_enable  = 1'b1;
            idex_enable  = 1'b1;
            exmem_enable = 1'b1;
            memwb_enable = 1'b1;
            // A taken branch squashes the dependent instruction, so its load-use is moot.
            if (ex_branch_taken) begin
                ifid_clear = 1'b1;
                idex_clear = 1'b1;
            end else if (w_load_use) begin
                pc_enable   = 1'b0;
                ifid_enable = 1'b0;
                idex_clear  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_timer     <= TMR_W'(1);
            r_mem_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state != MEM_WAIT) begin
                r_timer <= TMR_W'(1);
            end else if (r_timer != TMR_W'(MEM_TIMEOUT)) begin
                r_timer <= r_timer + 1'b1;
            end
            if ((r_state == MEM_WAIT) && (w_state_next == FAULT)) begin
                r_mem_fault <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwd_a <= FWD_REG;
            r_fwd_b <= FWD_REG;
        end else if (idex_clear) begin
            r_fwd_a <= FWD_REG;
            r_fwd_b <= FWD_REG;
        end else if (idex_enable) begin
            r_fwd_a <= fwd_select(id_rs1, w_sb_ex, w_sb_mem);
            r_fwd_b <= fwd_select(id_rs2, w_sb_ex, w_sb_mem);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (!pc_enable && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign forward_a    = r_fwd_a;
    assign forward_b    = r_fwd_b;
    assign mem_fault    = r_mem_fault;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Directed plus random bench against a behavioural pipeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 5;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_uses_rs1, id_uses_rs2, id_regwrite, id_memread;
    logic             ex_branch_taken, mem_req, mem_ready;
    logic             pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable;
    logic             ifid_clear, idex_clear, exmem_clear, memwb_clear;
    logic [1:0]       forward_a, forward_b;
    logic             mem_fault;
    logic [CNT_W-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_enable(pc_enable), .ifid_enable(ifid_enable), .idex_enable(idex_enable),
        .exmem_enable(exmem_enable), .memwb_enable(memwb_enable),
        .ifid_clear(ifid_clear), .idex_clear(idex_clear),
        .exmem_clear(exmem_clear), .memwb_clear(memwb_clear),
        .forward_a(forward_a), .forward_b(forward_b),
        .mem_fault(mem_fault), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Behavioural model: instructions in EX and MEM, a wait phase, counters.
    typedef struct { logic [4:0] rd; bit rw; bit mr; } ins_t;
    ins_t       m_ex, m_mem;
    int         m_phase;     // 0 running, 1 waiting on memory, 2 faulted
    int         m_waited;
    bit         m_fault;
    int         m_stalls;
    logic [1:0] m_fa, m_fb;
    bit         m_valid = 1'b0;
    bit         e_pc, e_ifid, e_idex, e_exmem, e_memwb;
    bit         e_ifid_clr, e_idex_clr;

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (rs != 5'd0 && m_ex.rw && m_ex.rd == rs) return 2'b01;
        if (rs != 5'd0 && m_mem.rw && m_mem.rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_eval();
        bit frozen, uses_load;
        frozen = (m_phase == 2) || (m_phase == 1 && !mem_ready) ||
                 (m_phase == 0 && mem_req && !mem_ready);
        uses_load = m_ex.mr && m_ex.rw && m_ex.rd != 5'd0 &&
                    ((id_uses_rs1 && id_rs1 == m_ex.rd) || (id_uses_rs2 && id_rs2 == m_ex.rd));
        {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = frozen ? 5'b00000 : 5'b11111;
        {e_ifid_clr, e_idex_clr} = 2'b00;
        if (!frozen && ex_branch_taken) begin
            {e_ifid_clr, e_idex_clr} = 2'b11;
        end else if (!frozen && uses_load) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_idex_clr = 1'b1;
        end
    endtask

    task automatic model_commit();
        if (reset) begin
            m_ex = '{5'd0, 1'b0, 1'b0}; m_mem = '{5'd0, 1'b0, 1'b0};
            m_phase = 0; m_waited = 0; m_fault = 1'b0; m_stalls = 0;
            m_fa = 2'b00; m_fb = 2'b00; m_valid = 1'b1;
            return;
        end
        if (e_idex_clr) begin
            m_fa = 2'b00; m_fb = 2'b00;
        end else if (e_idex) begin
            m_fa = model_fwd(id_rs1); m_fb = model_fwd(id_rs2);
        end
        if (e_exmem) m_mem = m_ex;
        if (e_idex_clr) m_ex = '{5'd0, 1'b0, 1'b0};
        else if (e_idex) m_ex = '{id_rd, id_regwrite, id_memread};
        if (!e_pc && m_stalls < CNT_MAX) m_stalls++;
        if (m_phase == 0 && mem_req && !mem_ready) begin
            m_phase = 1; m_waited = 1;
        end else if (m_phase == 1) begin
            if (mem_ready) m_phase = 0;
            else if (m_waited >= MEM_TIMEOUT) begin m_phase = 2; m_fault = 1'b1; end
            else m_waited++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_eval();
        @(negedge clk);
        if (m_valid) begin
            chk("enables", {27'd0, pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable},
                {27'd0, e_pc, e_ifid, e_idex, e_exmem, e_memwb});
            chk("clears", {28'd0, ifid_clear, idex_clear, exmem_clear, memwb_clear},
                {28'd0, e_ifid_clr, e_idex_clr, 2'b00});
            chk("forward_a", {30'd0, forward_a}, {30'd0, m_fa});
            chk("forward_b", {30'd0, forward_b}, {30'd0, m_fb});
            chk("mem_fault", {31'd0, mem_fault}, {31'd0, m_fault});
            chk("stall_cycles", {27'd0, stall_cycles}, m_stalls);
        end
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int rs1, input int rs2, input bit u1, input bit u2,
                          input int rd, input bit rw, input bit mr);
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rd = 5'(rd); id_regwrite = rw; id_memread = mr;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        reset = 1'b1; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        step(); step();
        reset = 1'b0;
        chk("reset_fwd", {30'd0, forward_a}, 32'd0);
        chk("reset_cnt", {27'd0, stall_cycles}, 32'd0);

        // Load-use: lw x5 then add x6,x5,x1
        set_id(0, 0, 0, 0, 5, 1, 1); step();
        set_id(5, 1, 1, 1, 6, 1, 0); #1;
        chk("lu_pc", {31'd0, pc_enable}, 32'd0);
        chk("lu_ifid", {31'd0, ifid_enable}, 32'd0);
        chk("lu_idex_clr", {31'd0, idex_clear}, 32'd1);
        step(); #1;
        chk("lu_one_cycle", {31'd0, pc_enable}, 32'd1);
        step();
        chk("lu_fwd_a", {30'd0, forward_a}, 32'd2);

        // ALU chain and two-apart dependency
        set_id(1, 2, 1, 1, 3, 1, 0); step();
        s0 = m_stalls;
        set_id(3, 3, 1, 1, 4, 1, 0); step();
        chk("chain_a", {30'd0, forward_a}, 32'd1);
        chk("chain_b", {30'd0, forward_b}, 32'd1);
        chk("chain_nostall", {27'd0, stall_cycles}, s0);
        set_id(1, 2, 1, 1, 7, 1, 0); step();
        set_id(0, 0, 0, 0, 0, 0, 0); step();
        set_id(7, 2, 1, 1, 8, 1, 0); step();
        chk("two_apart_a", {30'd0, forward_a}, 32'd2);

        // x0 producer never forwards
        set_id(0, 0, 1, 0, 0, 1, 0); step();
        set_id(0, 0, 1, 1, 1, 1, 0); step();
        chk("x0_a", {30'd0, forward_a}, 32'd0);
        chk("x0_b", {30'd0, forward_b}, 32'd0);

        // Branch coinciding with load-use
        set_id(0, 0, 0, 0, 9, 1, 1); step();
        set_id(9, 0, 1, 0, 10, 1, 0); ex_branch_taken = 1'b1; #1;
        chk("br_pc", {31'd0, pc_enable}, 32'd1);
        chk("br_clears", {30'd0, ifid_clear, idex_clear}, 32'd3);
        s0 = m_stalls;
        step();
        ex_branch_taken = 1'b0;
        chk("br_nostall", {27'd0, stall_cycles}, s0);

        // Memory wait of three cycles
        set_id(0, 0, 0, 0, 0, 0, 0);
        s0 = m_stalls; mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_frozen", {27'd0, pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable}, 32'd0);
            step();
        end
        mem_ready = 1'b1; #1;
        chk("mw_resume", {31'd0, pc_enable}, 32'd1);
        step();
        mem_req = 1'b0;
        chk("mw_count", {27'd0, stall_cycles}, s0 + 3);

        // Memory timeout
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (4) step();
        chk("flt_early", {31'd0, mem_fault}, 32'd0);
        step();
        chk("flt_set", {31'd0, mem_fault}, 32'd1);
        mem_req = 1'b0; mem_ready = 1'b1; #1;
        chk("flt_hold", {31'd0, pc_enable}, 32'd0);
        reset = 1'b1; step(); reset = 1'b0; #1;
        chk("flt_rst_fault", {31'd0, mem_fault}, 32'd0);
        chk("flt_rst_cnt", {27'd0, stall_cycles}, 32'd0);
        chk("flt_rst_pc", {31'd0, pc_enable}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            set_id(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   int'($urandom_range(0, 7)), ($urandom % 4) != 0, ($urandom % 3) == 0);
            ex_branch_taken = ($urandom % 8) == 0;
            mem_req         = ($urandom % 4) == 0;
            mem_ready       = ($urandom % 2) == 0;
            reset           = ($urandom % 60) == 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
